// File: rtl/seven_segment_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with double-buffered display data.
// Optional leading-zero blanking is enabled by defining SEVEN_SEGMENT_SCAN_LZB_EN.
module seven_segment_scan_ctrl #(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_COUNT    = 100000,
    parameter int BLANK_CYCLES     = 1000,
    parameter bit ACTIVE_LOW_ANODE = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_Rst_L,
    input  logic [4*NUM_DIGITS-1:0] i_Data,
    input  logic                    i_Load,
    input  logic [NUM_DIGITS-1:0]   i_Blank_Mask,
    output logic [3:0]              o_Digit_Data,
    output logic [NUM_DIGITS-1:0]   o_Anode,
    output logic                    o_Load_Ack,
    output logic                    o_Frame_Start
);
    localparam int CNT_W = $clog2(REFRESH_COUNT);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int DW    = 4 * NUM_DIGITS;
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
        ACTIVE_LOW_ANODE ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    generate
        if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || BLANK_CYCLES < 1 ||
            REFRESH_COUNT <= BLANK_CYCLES) begin : g_bad_params
            $error("seven_segment_scan_ctrl: illegal parameter combination");
        end
    endgenerate

    typedef enum logic {S_BLANK = 1'b0, S_DRIVE = 1'b1} state_t;

    // state, index and counter describe the slot position whose outputs are registered next
    state_t                state_r;
    logic [IDX_W-1:0]      idx_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [DW-1:0]         shadow_r;
    logic [DW-1:0]         pending_r;
    logic                  pend_flag_r;

    logic                  boundary_s;
    logic                  commit_s;
    logic [DW-1:0]         shadow_next_s;
    logic [3:0]            nib_s;
    logic [NUM_DIGITS-1:0] blank_s;
    logic [NUM_DIGITS-1:0] active_s;
    logic [NUM_DIGITS-1:0] anode_s;

    // Frame boundary detection, commit decision and next nibble/anode values
    always_comb begin
        boundary_s    = (cnt_r == {CNT_W{1'b0}}) && (idx_r == {IDX_W{1'b0}});
        commit_s      = boundary_s && pend_flag_r;
        shadow_next_s = commit_s ? pending_r : shadow_r;
        nib_s         = 4'h0;
        active_s      = {NUM_DIGITS{1'b0}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nib_s       = (idx_r == IDX_W'(k)) ? shadow_next_s[4*k +: 4] : nib_s;
            active_s[k] = (state_r == S_DRIVE) && (idx_r == IDX_W'(k)) && !blank_s[k];
        end
        anode_s = ACTIVE_LOW_ANODE ? ~active_s : active_s;
    end

`ifdef SEVEN_SEGMENT_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0] lzb_r;
    logic [NUM_DIGITS-1:0] lzb_s;

    function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input logic [DW-1:0] data);
        logic [NUM_DIGITS-1:0] mask;
        logic                  upper_zero;
        mask       = {NUM_DIGITS{1'b0}};
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (data[4*k +: 4] == 4'h0);
            mask[k]    = upper_zero;
        end
        return mask;
    endfunction

    // Leading-zero set follows the shadow value that becomes live at the boundary
    always_comb begin
        lzb_s   = boundary_s ? lead_zero_mask(shadow_next_s) : lzb_r;
        blank_s = i_Blank_Mask | lzb_s;
    end

    // Hold the leading-zero set for the rest of the frame
    always_ff @(posedge i_clk) begin
        if (!i_Rst_L) begin
            lzb_r <= lead_zero_mask({DW{1'b0}});
        end else begin
            lzb_r <= lzb_s;
        end
    end
`else
    // Only the host mask blanks digits
    always_comb begin
        blank_s = i_Blank_Mask;
    end
`endif

    // Scan FSM, slot counter, double buffer and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_Rst_L) begin
            state_r       <= S_BLANK;
            idx_r         <= {IDX_W{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            shadow_r      <= {DW{1'b0}};
            pending_r     <= {DW{1'b0}};
            pend_flag_r   <= 1'b0;
            o_Anode       <= ANODE_OFF;
            o_Digit_Data  <= 4'h0;
            o_Load_Ack    <= 1'b0;
            o_Frame_Start <= 1'b0;
        end else begin
            o_Anode       <= anode_s;
            o_Load_Ack    <= commit_s;
            o_Frame_Start <= boundary_s;
            shadow_r      <= shadow_next_s;
            // decoder input moves only at slot start so it settles during blanking
            if (cnt_r == {CNT_W{1'b0}}) begin
                o_Digit_Data <= nib_s;
            end else begin
                o_Digit_Data <= o_Digit_Data;
            end
            // a load coinciding with a commit still leaves fresh data pending
            if (i_Load) begin
                pending_r   <= i_Data;
                pend_flag_r <= 1'b1;
            end else if (commit_s) begin
                pend_flag_r <= 1'b0;
            end else begin
                pend_flag_r <= pend_flag_r;
            end
            cnt_r <= (cnt_r == CNT_W'(REFRESH_COUNT - 1)) ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
            case (state_r)
                S_BLANK: begin
                    if (cnt_r == CNT_W'(BLANK_CYCLES - 1)) begin
                        state_r <= S_DRIVE;
                    end else begin
                        state_r <= S_BLANK;
                    end
                end
                S_DRIVE: begin
                    if (cnt_r == CNT_W'(REFRESH_COUNT - 1)) begin
                        state_r <= S_BLANK;
                        idx_r   <= (idx_r == IDX_W'(NUM_DIGITS - 1)) ? {IDX_W{1'b0}}
                                                                     : idx_r + IDX_W'(1);
                    end else begin
                        state_r <= S_DRIVE;
                    end
                end
                default: begin
                    state_r <= S_BLANK;
                    idx_r   <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Scoreboard bench for seven_segment_scan_ctrl: a time-based reference model predicts every cycle.
// Follows SEVEN_SEGMENT_SCAN_LZB_EN when defined for the whole build.
module tb_seven_segment_scan_ctrl;
    localparam int ND    = 4;
    localparam int RC    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * RC;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic [15:0] data = 16'h0000;
    logic        load = 1'b0;
    logic [3:0]  mask = 4'h0;
    logic [3:0]  digit;
    logic [3:0]  anode;
    logic        ack;
    logic        frame;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] anode;
        logic [3:0] digit;
        logic       ack;
        logic       frame;
    } exp_t;
    exp_t q[$];

    // reference model state
    int          t = 0;
    logic [15:0] m_shadow = 16'h0000;
    logic [15:0] m_pending = 16'h0000;
    bit          m_flag = 1'b0;
    logic [3:0]  m_lz = 4'h0;

    seven_segment_scan_ctrl #(
        .NUM_DIGITS(ND), .REFRESH_COUNT(RC), .BLANK_CYCLES(BC), .ACTIVE_LOW_ANODE(1'b1)
    ) dut (
        .i_clk(clk), .i_Rst_L(rst_l), .i_Data(data), .i_Load(load),
        .i_Blank_Mask(mask), .o_Digit_Data(digit), .o_Anode(anode),
        .o_Load_Ack(ack), .o_Frame_Start(frame)
    );

    always #5 clk = ~clk;

    // digits above the most significant nonzero nibble are blank; digit 0 never is
    function automatic logic [3:0] lz_model(input logic [15:0] s);
        int msd;
        logic [3:0] all_ones;
        msd = 0;
        for (int k = 0; k < ND; k++) begin
            if (((s >> (4 * k)) & 16'h000F) != 16'h0000) msd = k;
        end
        all_ones = 4'hF;
`ifdef SEVEN_SEGMENT_SCAN_LZB_EN
        return all_ones << (msd + 1);
`else
        return all_ones & 4'h0;
`endif
    endfunction

    task automatic model_step();
        exp_t e;
        int p, dig, off;
        logic [3:0] onehot;
        if (!rst_l) begin
            m_shadow  = 16'h0000;
            m_pending = 16'h0000;
            m_flag    = 1'b0;
            t         = 0;
            e         = '{anode: 4'hF, digit: 4'h0, ack: 1'b0, frame: 1'b0};
        end else begin
            p   = t % FRAME;
            dig = p / RC;
            off = p % RC;
            e.ack   = 1'b0;
            e.frame = (p == 0);
            if (p == 0 && m_flag) begin
                m_shadow = m_pending;
                m_flag   = 1'b0;
                e.ack    = 1'b1;
            end
            if (p == 0) m_lz = lz_model(m_shadow);
            if (load) begin
                m_pending = data;
                m_flag    = 1'b1;
            end
            e.digit = 4'((m_shadow >> (4 * dig)) & 16'h000F);
            onehot  = 4'b0001 << dig;
            e.anode = (off < BC || mask[dig] || m_lz[dig]) ? 4'hF : ~onehot;
            t++;
        end
        q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // monitor: compare each registered output cycle against its prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (anode !== e.anode || digit !== e.digit || ack !== e.ack || frame !== e.frame) begin
                    errors++;
                    $display("FAIL scoreboard @%0t anode=%h exp %h digit=%h exp %h ack=%b exp %b frame=%b exp %b",
                             $time, anode, e.anode, digit, e.digit, ack, e.ack, frame, e.frame);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_frame();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (frame === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout no o_Frame_Start within %0d cycles, required one", 2 * FRAME);
        end
    endtask

    initial begin
        int acks;
        int n;

        // reset then idle frames
        run(3);
        rst_l = 1'b1;
        run(40);

        // single mid-frame load
        wait_frame();
        run(5);
        data = 16'h1A2F; load = 1'b1; tick(); load = 1'b0;
        run(40);

        // two loads in one frame: last wins, one ack
        wait_frame();
        run(4);
        data = 16'h1111; load = 1'b1; tick(); load = 1'b0;
        run(3);
        data = 16'h2222; load = 1'b1; tick(); load = 1'b0;
        acks = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL double_load_acks got %0d required 1", acks);
        end

        // load during the boundary cycle commits one frame later
        wait_frame();
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL boundary_no_ack got %b required 0", ack);
        end
        data = 16'h3333; load = 1'b1; tick(); load = 1'b0;
        n = 1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            n++;
            if (ack === 1'b1) break;
        end
        checks++;
        if (n != FRAME) begin
            errors++;
            $display("FAIL boundary_load_latency got %0d cycles required %0d", n, FRAME);
        end

        // host blank mask on digit 2
        mask = 4'b0100;
        run(2 * FRAME);
        mask = 4'b0000;

        // small value: leading digits blank only when that feature is built in
        data = 16'h0070; load = 1'b1; tick(); load = 1'b0;
        run(2 * FRAME + 4);

        // randomized loads, data widths and masks
        for (int i = 0; i < 600; i++) begin
            load = ($urandom_range(0, 15) == 0);
            data = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 3)));
            if ($urandom_range(0, 31) == 0) mask = 4'($urandom_range(0, 15));
            tick();
        end
        load = 1'b0;
        mask = 4'h0;

        // reset while a digit is being driven, with a pending load to discard
        wait_frame();
        data = 16'hBEEF; load = 1'b1; tick(); load = 1'b0;
        run(3);
        rst_l = 1'b0;
        tick();
        checks++;
        if (anode !== 4'hF) begin
            errors++;
            $display("FAIL reset_mid_drive anode got %h required f", anode);
        end
        tick();
        rst_l = 1'b1;
        run(2 * FRAME + 4);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain %0d entries left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_segment_scan_ctrl.md
Name: seven_segment_scan_ctrl

Overview:
- Time-multiplexes one shared registered hex-to-segment decoder (1-cycle latency, 4-bit nibble in) across NUM_DIGITS common-anode digits.
- Sequences the digit index, drives the decoder nibble and the digit anodes, and inserts a blanking gap between digits to prevent ghosting.
- Display data is double-buffered: host loads go to a pending register and are committed to the shadow register only at frame boundaries.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits, range 2..8.
- REFRESH_COUNT, 100000: clock cycles per digit slot; must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes inactive; minimum 1, which covers decoder latency.
- ACTIVE_LOW_ANODE, 1: 1 = anode active low, 0 = active high.

Ports:
- i_clk, input, 1: system clock.
- i_Rst_L, input, 1: synchronous active-low reset.
- i_Data, input, 4*NUM_DIGITS: display nibbles; digit k = i_Data[4k+3:4k], and digit 0 is rightmost.
- i_Load, input, 1: single-cycle strobe that captures i_Data into the pending register.
- i_Blank_Mask, input, NUM_DIGITS: 1 = keep that digit's anode off. Sampled live.
- o_Digit_Data, output, 4: nibble to the decoder.
- o_Anode, output, NUM_DIGITS: digit enables.
- o_Load_Ack, output, 1: one-cycle pulse when pending data is committed to the shadow register.
- o_Frame_Start, output, 1: one-cycle pulse on entry to the digit-0 blank phase.

Behaviour:
- Reset, checked on i_clk while i_Rst_L=0:
  - state=S_BLANK; digit index=0; slot counter=0.
  - shadow=0; pending=0; pending flag=0.
  - o_Anode=all inactive (all 1s if ACTIVE_LOW_ANODE, else all 0s); o_Digit_Data=0; o_Load_Ack=0; o_Frame_Start=0.
  - Reset mid-slot aborts immediately; pending data is discarded.
- Slot counter counts 0..REFRESH_COUNT-1 and wraps.
- FSM, two states:
  - S_BLANK, counter 0..BLANK_CYCLES-1: all anodes inactive; o_Digit_Data=shadow nibble of the current index. At counter=BLANK_CYCLES-1, go to S_DRIVE.
  - S_DRIVE, counter BLANK_CYCLES..REFRESH_COUNT-1: o_Anode asserts only bit [index], unless the digit is blanked. At counter=REFRESH_COUNT-1: index increments, wrapping NUM_DIGITS-1 to 0; counter returns to 0; state goes to S_BLANK.
- Digit blanking: the anode stays inactive for the whole slot, but slot timing is unchanged.
- Decoder alignment: o_Digit_Data changes only on the first S_BLANK cycle of a slot, so the decoder output is stable at least BLANK_CYCLES-1 cycles before the anode asserts.
- Frame boundary is the first cycle of the digit-0 S_BLANK phase. In that cycle:
  - o_Frame_Start=1.
  - If the pending flag was set at the end of the previous cycle: shadow<=pending, flag clears, o_Load_Ack=1 in the same cycle.
  - o_Digit_Data on this cycle already reflects the newly committed shadow.
- Load rules:
  - i_Load with the flag already set overwrites pending (last wins); only one ack is issued.
  - i_Load on the boundary cycle itself is captured into pending and commits at the next frame. Any flag set before that cycle is still committed now.
- Registered outputs: all outputs are registered; o_Anode and o_Digit_Data have no combinational path from inputs.
- Frame period = NUM_DIGITS*REFRESH_COUNT cycles; the first frame starts on the first cycle after reset release.
- All counters are sized with $clog2. No overflow is possible because the parameter constraints above are enforced by an elaboration-time check.

Optional Feature:
- Macro: SEVEN_SEGMENT_SCAN_LZB_EN.
- Defined: leading-zero blanking. Digits above the most-significant nonzero shadow nibble are forced blank, ORed with i_Blank_Mask. Digit 0 is never forced blank, so shadow 0 displays a single "0". The blank set is recomputed from shadow at each frame boundary.
- Undefined: only i_Blank_Mask blanks digits; zeros are displayed.

Test Plan (NUM_DIGITS=4, REFRESH_COUNT=8, BLANK_CYCLES=2, ACTIVE_LOW_ANODE=1):
1. Reset held 3 cycles, then released -> o_Anode=4'hF and o_Digit_Data=0 during reset; o_Frame_Start pulses on the first post-reset cycle; o_Anode=4'hE at cycles 2..7, 4'hD at cycles 10..15, and 4'hF at cycles 0-1 and 8-9.
2. i_Load with i_Data=16'h1A2F mid-frame -> o_Load_Ack and o_Frame_Start pulse together at the next boundary; o_Digit_Data sequence per slot is F, 2, A, 1.
3. i_Load 16'h1111, then i_Load 16'h2222 within the same frame -> exactly one o_Load_Ack; displayed nibbles are all 2.
4. i_Load 16'h3333 on the exact boundary cycle -> no ack this boundary; ack and commit occur one frame (32 cycles) later.
5. i_Blank_Mask=4'b0100 -> o_Anode never equals 4'hB; digit-2 slot keeps 4'hF for all 8 cycles; frame period remains 32 cycles.
6. Macro defined, shadow 16'h0070 -> digits 2 and 3 anodes never assert; digits 0 and 1 show 0 and 7. Reset asserted mid-S_DRIVE -> o_Anode=4'hF on the next edge, and the shadow reads 0 afterwards.
